snd_cmd_bridge: RTL and testbench

Parametrised multi-channel command bridge between the main CPU bus and the sound processors. Each channel is a FIFO-buffered command latch with its own IRQ flip-flop. It replaces the fixed single-byte sound latches and the hand-built set/clear IRQ register used in the single-board top levels. With DEPTH=1 and OVERWRITE=1 it reproduces the legacy latch exactly; deeper settings let a fast main CPU queue commands without losing them.

---
 rtl/snd_cmd_bridge.sv | 119 +++++++++++
 tb/tb_snd_cmd_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_cmd_bridge.sv
// snd_cmd_bridge: multi-channel command bridge from the main CPU bus to the
// sound processors. Each channel is a small FWFT FIFO with its own IRQ
// flip-flop and sticky overflow flag. DEPTH=1 with OVERWRITE=1 behaves as the
// classic single-byte sound latch.
module snd_cmd_bridge #(
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter int OVERWRITE = 0,
  parameter int AUTO_IRQ  = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   cen,
  input  logic                   wr_en,
  input  logic [CW-1:0]          wr_ch,
  input  logic [DW-1:0]          wr_data,
  input  logic [CHANNELS-1:0]    irq_trig,
  input  logic [CHANNELS-1:0]    irq_ack_n,
  input  logic [CHANNELS-1:0]    rd_en,
  output logic [CHANNELS*DW-1:0] rd_data,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS*LW-1:0] level,
  output logic [CHANNELS-1:0]    irq_n,
  output logic [CHANNELS-1:0]    overflow,
  input  logic [CHANNELS-1:0]    ovf_clr
);

  // Pointer width is at least one bit; with DEPTH=1 the pointers are pinned
  // to zero and the second storage slot is never touched.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = 1 << PW;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DW-1:0] mem [MW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] wr_ptr_dec;
    logic [PW-1:0] rd_ptr_inc;
    logic [LW-1:0] cnt;
    logic          is_empty;
    logic          is_full;
    logic          push_req;
    logic          pop_ok;
    logic          push_ok;
    logic          push_ovw;
    logic          irq_set;
    logic          irq_q;
    logic          ovf_q;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == LW'(DEPTH));
    // Out-of-range channel numbers never match any channel index.
    assign push_req = cen & wr_en & (wr_ch == CW'(c));
    assign pop_ok   = rd_en[c] & ~is_empty;
    // A pop in the same cycle frees a slot, so a push to a full channel
    // still lands normally.
    assign push_ok  = push_req & (~is_full | pop_ok);
    assign push_ovw = push_req & is_full & ~pop_ok;

    assign wr_ptr_inc = (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
    assign wr_ptr_dec = (DEPTH == 1) ? '0 : wr_ptr - 1'b1;
    assign rd_ptr_inc = (DEPTH == 1) ? '0 : rd_ptr + 1'b1;

    assign irq_set = (cen & irq_trig[c]) |
                     ((AUTO_IRQ != 0) & (push_ok | (push_ovw & (OVERWRITE != 0))));

    // Storage write; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk_49m) begin
      if (!reset) begin
        if (push_ok)
          mem[wr_ptr] <= wr_data;
        else if (push_ovw && (OVERWRITE != 0))
          mem[wr_ptr_dec] <= wr_data;
      end
    end

    // Pointers, word count, IRQ and overflow flag.
    always_ff @(posedge clk_49m) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        irq_q  <= 1'b1;
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr_inc;
        if (pop_ok)  rd_ptr <= rd_ptr_inc;

        if (push_ok && !pop_ok)
          cnt <= cnt + 1'b1;
        else if (pop_ok && !push_ok)
          cnt <= cnt - 1'b1;

        if (!irq_ack_n[c])
          irq_q <= 1'b1;
        else if (irq_set)
          irq_q <= 1'b0;

        if (ovf_clr[c])
          ovf_q <= 1'b0;
        else if (push_ovw)
          ovf_q <= 1'b1;
      end
    end

    assign rd_data[c*DW +: DW] = is_empty ? '0 : mem[rd_ptr];
    assign empty[c]            = is_empty;
    assign full[c]             = is_full;
    assign level[c*LW +: LW]   = cnt;
    assign irq_n[c]            = irq_q;
    assign overflow[c]         = ovf_q;
  end

endmodule

// File: tb/tb_snd_cmd_bridge.sv
// Bench for snd_cmd_bridge: two instances (a 2x4 dropping FIFO and a 3x1
// legacy latch with auto IRQ) driven by directed and random stimulus and
// checked every cycle against a queue-based reference model.
module tb_snd_cmd_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cen;
  logic [7:0] wr_data;

  // instance A: CHANNELS=2, DEPTH=4, OVERWRITE=0, AUTO_IRQ=0
  logic        wr_en_a;
  logic [0:0]  wr_ch_a;
  logic [1:0]  irq_trig_a, irq_ack_n_a, rd_en_a, ovf_clr_a;
  logic [15:0] rd_data_a;
  logic [1:0]  empty_a, full_a, irq_n_a, overflow_a;
  logic [5:0]  level_a;

  // instance B: CHANNELS=3, DEPTH=1, OVERWRITE=1, AUTO_IRQ=1
  logic        wr_en_b;
  logic [1:0]  wr_ch_b;
  logic [2:0]  irq_trig_b, irq_ack_n_b, rd_en_b, ovf_clr_b;
  logic [23:0] rd_data_b;
  logic [2:0]  empty_b, full_b, irq_n_b, overflow_b;
  logic [2:0]  level_b;

  snd_cmd_bridge #(.CHANNELS(2), .DEPTH(4), .DW(8), .OVERWRITE(0), .AUTO_IRQ(0)) u_a (
    .clk_49m(clk), .reset(reset), .cen(cen), .wr_en(wr_en_a), .wr_ch(wr_ch_a),
    .wr_data(wr_data), .irq_trig(irq_trig_a), .irq_ack_n(irq_ack_n_a),
    .rd_en(rd_en_a), .rd_data(rd_data_a), .empty(empty_a), .full(full_a),
    .level(level_a), .irq_n(irq_n_a), .overflow(overflow_a), .ovf_clr(ovf_clr_a)
  );

  snd_cmd_bridge #(.CHANNELS(3), .DEPTH(1), .DW(8), .OVERWRITE(1), .AUTO_IRQ(1)) u_b (
    .clk_49m(clk), .reset(reset), .cen(cen), .wr_en(wr_en_b), .wr_ch(wr_ch_b),
    .wr_data(wr_data), .irq_trig(irq_trig_b), .irq_ack_n(irq_ack_n_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .empty(empty_b), .full(full_b),
    .level(level_b), .irq_n(irq_n_b), .overflow(overflow_b), .ovf_clr(ovf_clr_b)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int ch, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0h, want %0h", nm, ch, got, exp);
    end
  endtask

  // Reference model: one queue per channel, plus IRQ and overflow bits.
  logic [7:0] mq [2][3][$];
  bit         mirq [2][3];
  bit         movf [2][3];

  task automatic model_step(input int k, input int chn, input int dep, input bit ovw,
                            input bit aut, input bit we, input int ch, input logic [7:0] d,
                            input logic [7:0] trig, input logic [7:0] ack,
                            input logic [7:0] rd, input logic [7:0] clr);
    for (int c = 0; c < chn; c++) begin
      bit push, pop, is_full, acc, over;
      if (reset) begin
        mq[k][c].delete();
        mirq[k][c] = 1'b1;
        movf[k][c] = 1'b0;
      end else begin
        push    = cen && we && (ch == c);
        pop     = rd[c] && (mq[k][c].size() != 0);
        is_full = (mq[k][c].size() == dep);
        acc     = push && (!is_full || pop);
        over    = push && is_full && !pop;
        if (pop) void'(mq[k][c].pop_front());
        if (acc) mq[k][c].push_back(d);
        if (over && ovw) mq[k][c][mq[k][c].size()-1] = d;
        if (clr[c]) movf[k][c] = 1'b0;
        else if (over) movf[k][c] = 1'b1;
        if (!ack[c]) mirq[k][c] = 1'b1;
        else if ((cen && trig[c]) || (aut && (acc || (over && ovw)))) mirq[k][c] = 1'b0;
      end
    end
  endtask

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    model_step(0, 2, 4, 1'b0, 1'b0, wr_en_a, int'(wr_ch_a), wr_data,
               {6'b0, irq_trig_a}, {6'h3f, irq_ack_n_a}, {6'b0, rd_en_a}, {6'b0, ovf_clr_a});
    model_step(1, 3, 1, 1'b1, 1'b1, wr_en_b, int'(wr_ch_b), wr_data,
               {5'b0, irq_trig_b}, {5'h1f, irq_ack_n_b}, {5'b0, rd_en_b}, {5'b0, ovf_clr_b});
  end

  // Compare every output of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        chk("a_rd_data", c, rd_data_a[c*8 +: 8], (mq[0][c].size() != 0) ? mq[0][c][0] : 8'h00);
        chk("a_level", c, level_a[c*3 +: 3], mq[0][c].size());
        chk("a_empty", c, empty_a[c], mq[0][c].size() == 0);
        chk("a_full", c, full_a[c], mq[0][c].size() == 4);
        chk("a_irq_n", c, irq_n_a[c], mirq[0][c]);
        chk("a_overflow", c, overflow_a[c], movf[0][c]);
      end
      for (int c = 0; c < 3; c++) begin
        chk("b_rd_data", c, rd_data_b[c*8 +: 8], (mq[1][c].size() != 0) ? mq[1][c][0] : 8'h00);
        chk("b_level", c, level_b[c], mq[1][c].size());
        chk("b_empty", c, empty_b[c], mq[1][c].size() == 0);
        chk("b_full", c, full_b[c], mq[1][c].size() == 1);
        chk("b_irq_n", c, irq_n_b[c], mirq[1][c]);
        chk("b_overflow", c, overflow_b[c], movf[1][c]);
      end
    end
  end

  task automatic idle();
    reset = 1'b0;
    cen = 1'b1;
    wr_en_a = 1'b0;  wr_en_b = 1'b0;
    rd_en_a = '0;    rd_en_b = '0;
    irq_trig_a = '0; irq_trig_b = '0;
    irq_ack_n_a = '1; irq_ack_n_b = '1;
    ovf_clr_a = '0;  ovf_clr_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    wr_data = 8'h00;
    wr_ch_a = '0;
    wr_ch_b = '0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_empty_a", -1, empty_a, 2'b11);
    chk("rst_level_a", -1, level_a, 6'd0);
    chk("rst_irq_n_a", -1, irq_n_a, 2'b11);
    chk("rst_rd_data_b", -1, rd_data_b, 24'h0);
    idle();

    // basic push of 0x11, 0x22 to channel 1
    wr_en_a = 1'b1; wr_ch_a = 1'b1; wr_data = 8'h11;
    tick();
    chk("push_latency", 1, rd_data_a[15:8], 8'h11);
    wr_data = 8'h22;
    tick();
    idle();
    chk("push_level", 1, level_a[5:3], 3'd2);
    chk("push_empty", -1, empty_a, 2'b01);
    chk("push_head", 1, rd_data_a[15:8], 8'h11);
    chk("push_ch0_data", 0, rd_data_a[7:0], 8'h00);

    // cen gating: strobes without cen are ignored
    cen = 1'b0; wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data = 8'h99;
    repeat (7) tick();
    idle();
    chk("cen_gate_level", 0, level_a[2:0], 3'd0);

    // fill channel 0 past full: fifth word dropped
    for (int i = 1; i <= 5; i++) begin
      wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data = 8'(i);
      tick();
    end
    idle();
    chk("fill_full", 0, full_a[0], 1'b1);
    chk("fill_ovf", 0, overflow_a[0], 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 0, rd_data_a[7:0], 8'(i));
      rd_en_a = 2'b01;
      tick();
    end
    idle();
    chk("drain_empty", 0, empty_a[0], 1'b1);
    chk("drain_zero", 0, rd_data_a[7:0], 8'h00);
    rd_en_a = 2'b01;
    tick();
    idle();
    chk("pop_empty_ovf", 0, overflow_a[0], 1'b1);
    ovf_clr_a = 2'b01;
    tick();
    idle();
    chk("ovf_clear", 0, overflow_a[0], 1'b0);

    // legacy latch: second write replaces the first
    wr_en_b = 1'b1; wr_ch_b = 2'd0; wr_data = 8'hA5;
    tick();
    chk("auto_irq", 0, irq_n_b, 3'b110);
    chk("legacy_first", 0, rd_data_b[7:0], 8'hA5);
    wr_data = 8'h3C;
    tick();
    chk("legacy_data", 0, rd_data_b[7:0], 8'h3C);
    chk("legacy_level", 0, level_b[0], 1'b1);
    chk("legacy_ovf", 0, overflow_b[0], 1'b1);
    wr_ch_b = 2'd3; wr_data = 8'h77;
    tick();
    idle();
    chk("out_of_range", -1, rd_data_b, 24'h00003C);

    // push+pop at full keeps level at 4 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data = 8'(8'h40 + i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk("stream_head", 0, rd_data_a[7:0], 8'(8'h40 + i));
      wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data = 8'(8'h44 + i); rd_en_a = 2'b01;
      tick();
      chk("stream_level", 0, level_a[2:0], 3'd4);
      chk("stream_no_ovf", 0, overflow_a[0], 1'b0);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("stream_tail", 0, rd_data_a[7:0], 8'(8'h48 + i));
      rd_en_a = 2'b01;
      tick();
    end
    idle();

    // IRQ set, acknowledge, and acknowledge winning over trigger
    irq_trig_a = 2'b01;
    tick();
    idle();
    chk("irq_set", -1, irq_n_a, 2'b10);
    irq_ack_n_a = 2'b10;
    tick();
    idle();
    chk("irq_ack", -1, irq_n_a, 2'b11);
    irq_ack_n_a = 2'b10; irq_trig_a = 2'b01;
    tick();
    idle();
    chk("irq_ack_prio", -1, irq_n_a, 2'b11);

    // reset mid-queue, with live inputs during the reset cycle
    wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data = 8'h5A; irq_trig_a = 2'b10;
    tick();
    reset = 1'b1; wr_en_b = 1'b1; wr_ch_b = 2'd1; irq_trig_b = 3'b111;
    tick();
    idle();
    chk("mid_rst_empty", -1, empty_a, 2'b11);
    chk("mid_rst_data", -1, rd_data_a, 16'h0);
    chk("mid_rst_irq", -1, irq_n_a, 2'b11);
    chk("mid_rst_b", -1, {irq_n_b, overflow_b, empty_b}, 9'b111_000_111);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      cen     = ($urandom_range(0, 3) != 0);
      wr_data = 8'($urandom);
      wr_en_a = (i < 1500) ? ($urandom_range(0, 7) != 0) : 1'($urandom);
      wr_ch_a = 1'($urandom);
      wr_en_b = 1'($urandom);
      wr_ch_b = 2'($urandom);
      rd_en_a = (i < 1500) ? (2'($urandom) & 2'($urandom)) : 2'($urandom);
      rd_en_b = 3'($urandom) & 3'($urandom);
      irq_trig_a = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      irq_trig_b = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      irq_ack_n_a = ~(2'($urandom) & 2'($urandom) & 2'($urandom));
      irq_ack_n_b = ~(3'($urandom) & 3'($urandom) & 3'($urandom));
      ovf_clr_a = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      ovf_clr_b = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
